// File: rtl/mips_pkg.sv
// mips_pkg: constants, the fetch buffer entry type and the jump-target helper
// shared by the fetch front end.
package mips_pkg;

    localparam int unsigned INSN_W  = 32;
    localparam int unsigned ADDR_W  = 32;

    // Opcode and j-target field positions within an instruction word
    localparam int unsigned OP_MSB  = 31;
    localparam int unsigned OP_LSB  = 26;
    localparam int unsigned TGT_MSB = 25;
    localparam int unsigned TGT_LSB = 0;

    localparam logic [5:0]        OPCODE_J         = 6'b000010;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One buffered fetch: the word and the byte address it came from
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INSN_W-1:0] ins;
    } fetch_entry_t;

    // j target: region bits of pc+4 concatenated with the word-aligned index
    function automatic logic [ADDR_W-1:0] jump_target(
        input logic [ADDR_W-1:0] pc_plus4,
        input logic [INSN_W-1:0] ins
    );
        return {pc_plus4[31:28], ins[TGT_MSB:TGT_LSB], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry prefetch buffer of {pc, ins} pairs.
// Ports: clk, rst (async, active-high), push/pop/flush controls, wr_pc/wr_ins
// write data, head_pc/head_ins head entry (raw, ungated), count occupancy.
// Flush empties the buffer and overrides push and pop on the same edge.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [31:0]            wr_pc,
    input  logic [31:0]            wr_ins,
    output logic [31:0]            head_pc,
    output logic [31:0]            head_ins,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t        mem [DEPTH];
    logic [AW-1:0]       wptr;
    logic [AW-1:0]       rptr;

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed while count is nonzero
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wptr] <= '{pc: wr_pc, ins: wr_ins};
        end
    end

    assign head_pc  = mem[rptr].pc;
    assign head_ins = mem[rptr].ins;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: program counter, next-PC selection and prefetch buffer
// feeding decode over a valid/ready handshake.
// Ports: clk, rst (async, active-high); imem_addr/imem_ins combinational
// instruction memory; out_valid/out_ready/out_ins/out_pc to decode;
// redirect_valid/redirect_pc flush-and-restart from decode/execute.
// Build option: FETCH_JUMP_PREDECODE_EN follows j words locally instead of
// waiting for a redirect from decode.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_ins,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ins,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]   pc;
    logic [31:0]   pc_plus4;
    logic [31:0]   next_pc;
    logic [CW-1:0] count;
    logic [31:0]   head_pc;
    logic [31:0]   head_ins;
    logic          push;
    logic          pop;
    logic          unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    // out_valid depends only on registered occupancy, never on out_ready
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // A pop frees the slot the same edge, so a full buffer keeps streaming
    assign push      = !redirect_valid && ((count < CW'(DEPTH)) || pop);

    assign out_ins   = out_valid ? head_ins : 32'h0;
    assign out_pc    = out_valid ? head_pc  : 32'h0;

    // Next fetch address for a push edge
    always_comb begin
        next_pc = pc_plus4;
`ifdef FETCH_JUMP_PREDECODE_EN
        if (imem_ins[OP_MSB:OP_LSB] == OPCODE_J) begin
            next_pc = jump_target(pc_plus4, imem_ins);
        end
`endif
    end

    // Program counter: redirect beats push; otherwise hold while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            pc <= next_pc;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_valid),
        .wr_pc    (pc),
        .wr_ins   (imem_ins),
        .head_pc  (head_pc),
        .head_ins (head_ins),
        .count    (count)
    );

endmodule
